// File: rtl/event_reader.sv
// =============================================================================
// Module  : event_reader
// Purpose : Latches a 16x64-bit event snapshot on event_ready and streams it out
//           as 32 AXI4-Stream words. Optional header word under the
//           EVENT_READER_HEADER_EN macro.
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module event_reader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             event_ready,
  input  logic [15:0][63:0] evento,
  output logic             event_saved,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [15:0]      event_count
);

  localparam int C_SYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
`ifdef EVENT_READER_HEADER_EN
  localparam logic [2:0] HEADER = 3'd2;
`endif
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] SAVED  = 3'd4;

  logic [C_SYNC-1:0] sync_q, sync_d;
  logic [2:0]        state_q, state_d;
  logic [1023:0]     evt_buf_q, evt_buf_d;
  logic [4:0]        idx_q, idx_d;
  logic [31:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              saved_q, saved_d;
  logic [15:0]       event_count_q, event_count_d;

  logic       rdy_s;
  logic       hs;
  logic [4:0] idx_nx;

  assign rdy_s  = sync_q[C_SYNC-1];
  assign hs     = tvalid_q & m_axis_tready;
  assign idx_nx = idx_q + 5'd1;

  always_comb begin
    sync_d        = {sync_q[C_SYNC-2:0], event_ready};
    state_d       = state_q;
    evt_buf_d     = evt_buf_q;
    idx_d         = idx_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    saved_d       = saved_q;
    event_count_d = event_count_q;

    case (state_q)
      IDLE: begin
        if (rdy_s) state_d = LATCH;
      end
      LATCH: begin
        // First word is taken from the live input since the buffer loads this edge.
        evt_buf_d = evento;
        idx_d     = 5'd0;
        tvalid_d  = 1'b1;
        tlast_d   = 1'b0;
`ifdef EVENT_READER_HEADER_EN
        tdata_d   = {16'hA5A5, event_count_q};
        state_d   = HEADER;
`else
        tdata_d   = evento[0][31:0];
        state_d   = SEND;
`endif
      end
`ifdef EVENT_READER_HEADER_EN
      HEADER: begin
        if (hs) begin
          tdata_d = evt_buf_q[31:0];
          state_d = SEND;
        end
      end
`endif
      SEND: begin
        if (hs) begin
          if (idx_q == 5'd31) begin
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            saved_d       = 1'b1;
            event_count_d = event_count_q + 16'd1;
            state_d       = SAVED;
          end else begin
            idx_d   = idx_nx;
            tdata_d = evt_buf_q[{idx_nx, 5'd0} +: 32];
            tlast_d = (idx_nx == 5'd31);
          end
        end
      end
      SAVED: begin
        if (!rdy_s) begin
          saved_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync_q        <= '0;
      state_q       <= IDLE;
      evt_buf_q     <= '0;
      idx_q         <= 5'd0;
      tdata_q       <= 32'd0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      saved_q       <= 1'b0;
      event_count_q <= 16'd0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      evt_buf_q     <= evt_buf_d;
      idx_q         <= idx_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      saved_q       <= saved_d;
      event_count_q <= event_count_d;
    end
  end

  assign event_saved   = saved_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign event_count   = event_count_q;

endmodule

`default_nettype wire

// File: tb/tb_event_reader.sv
// =============================================================================
// Module  : tb_event_reader
// Purpose : Randomized scoreboard bench for event_reader (header mode follows
//           the EVENT_READER_HEADER_EN macro).
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_event_reader;

  localparam int SYNC = 2;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             event_ready = 1'b0;
  logic [15:0][63:0] evento = '0;
  logic             event_saved;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tlast;
  logic [15:0]      event_count;

  event_reader #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .areset       (areset),
    .event_ready  (event_ready),
    .evento       (evento),
    .event_saved  (event_saved),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          popped = 0;
  longint      last_hs = 0;
  logic [15:0] model_count = 16'd0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream: optional header, then word k = low/high half of channel k/2.
  task automatic push_event();
    logic [63:0] ch;
`ifdef EVENT_READER_HEADER_EN
    exp_q.push_back({1'b0, 16'hA5A5, model_count});
`endif
    for (int k = 0; k < 32; k++) begin
      ch = evento[k / 2];
      exp_q.push_back({(k == 31), ((k % 2) == 1) ? ch[63:32] : ch[31:0]});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin : monitor
    bit          stall = 1'b0;
    logic [32:0] held = '0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (areset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          chk("stall_hold", 64'({m_axis_tlast, m_axis_tdata}), 64'(held));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
            popped++;
            if (e[32]) last_hs = $time;
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        held  = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  task automatic randomize_event();
    for (int c = 0; c < 16; c++) evento[c] = {$urandom, $urandom};
  endtask

  // mode 0: normal handshake; mode 1: event_ready drops while streaming.
  task automatic run_event(input bit lat_chk, input int mode);
    int n;
    push_event();
    @(posedge clk);
    #1;
    event_ready = 1'b1;
    if (lat_chk) begin
      repeat (SYNC + 1) @(posedge clk);
      #1;
      chk("tvalid_early", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      chk("tvalid_latency", 64'(m_axis_tvalid), 64'd1);
    end
    if (mode == 1) begin
      n = 0;
      while (!m_axis_tvalid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      event_ready = 1'b0;
    end
    n = 0;
    while (!event_saved && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("saved_timeout", 64'(event_saved), 64'd1);
    chk("saved_delay", 64'($time - last_hs), 64'd6);
    model_count = model_count + 16'd1;
    chk("event_count", 64'(event_count), 64'(model_count));
    chk("all_words_sent", 64'(exp_q.size()), 64'd0);
    chk("tvalid_after", 64'(m_axis_tvalid), 64'd0);
    if (mode == 1) begin
      @(posedge clk);
      #1;
      chk("saved_pulse", 64'(event_saved), 64'd0);
    end else begin
      event_ready = 1'b0;
      repeat (SYNC) @(posedge clk);
      #1;
      chk("saved_hold", 64'(event_saved), 64'd1);
      @(posedge clk);
      #1;
      chk("saved_fall", 64'(event_saved), 64'd0);
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #23;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_saved", 64'(event_saved), 64'd0);
    chk("rst_count", 64'(event_count), 64'd0);
    @(negedge clk);
    areset = 1'b0;
    repeat (3) @(posedge clk);

    for (int c = 0; c < 16; c++) evento[c] = {32'(2 * c + 1), 32'(2 * c)};
    run_event(1'b1, 0);

    rand_ready = 1'b1;
    randomize_event();
    run_event(1'b1, 0);
    randomize_event();
    run_event(1'b0, 1);

    // Abort mid-event: partial event discarded, state fully cleared.
    rand_ready = 1'b0;
    randomize_event();
    push_event();
    @(posedge clk);
    #1;
    event_ready = 1'b1;
    n = popped + 10;
    while (popped < n && n < 1000000) begin
      @(posedge clk);
      n = (popped < n) ? n : n;
      if ($time > 1_500_000) break;
    end
    @(posedge clk);
    #2;
    areset = 1'b1;
    event_ready = 1'b0;
    exp_q.delete();
    model_count = 16'd0;
    #1;
    chk("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("abort_tlast", 64'(m_axis_tlast), 64'd0);
    chk("abort_count", 64'(event_count), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    repeat (3) @(posedge clk);

    randomize_event();
    run_event(1'b1, 0);

    // Wrap: preload the counter to its maximum while idle.
    @(negedge clk);
    force dut.event_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.event_count_q;
    @(negedge clk);
    chk("count_preload", 64'(event_count), 64'hFFFF);
    model_count = 16'hFFFF;
    rand_ready = 1'b1;
    randomize_event();
    run_event(1'b0, 0);
    chk("count_wrap", 64'(event_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
